// File: rtl/mem_arbiter.sv
// Round-robin block-transfer arbiter: serves NCHAN cache requesters over one Sysbus port,
// splitting each BLOCKSZ-bit line into BUS_DATA_WIDTH-bit beats, one transaction at a time.
module mem_arbiter #(
    parameter int unsigned NCHAN          = 2,
    parameter int unsigned WORDSZ         = 64,
    parameter int unsigned BLOCKSZ        = 512,
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCHAN-1:0]            req_valid,
    input  logic [NCHAN-1:0]            req_write,
    input  logic [NCHAN*WORDSZ-1:0]     req_addr,
    input  logic [NCHAN*BLOCKSZ-1:0]    req_wdata,
    output logic [NCHAN-1:0]            req_accept,
    output logic [NCHAN-1:0]            resp_valid,
    output logic [BLOCKSZ-1:0]          resp_data,
    output logic                        bus_reqcyc,
    output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
    output logic [BUS_DATA_WIDTH-1:0]   bus_req,
    input  logic                        bus_reqack,
    input  logic                        bus_respcyc,
    input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
    input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
    output logic                        bus_respack
);

    localparam int unsigned BEATS  = BLOCKSZ / BUS_DATA_WIDTH;
    localparam int unsigned BEAT_W = $clog2(BEATS) + 1;
    localparam int unsigned CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned OFF_W  = $clog2(BLOCKSZ / 8);
    localparam int unsigned ID_W   = BUS_TAG_WIDTH - 5;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WORDSZ-1:0] ADDR_MASK = {WORDSZ{1'b1}} << OFF_W;

    typedef enum logic [2:0] {StIdle, StAddr, StWdata, StRdata, StDone} state_e;

    state_e                    state_q, state_d;
    logic [CHAN_W-1:0]         chan_q, chan_d;
    logic                      write_q, write_d;
    logic [WORDSZ-1:0]         addr_q, addr_d;
    logic [BLOCKSZ-1:0]        wdata_q, wdata_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [BLOCKSZ-1:0]        line_q, line_d;
    logic [CHAN_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [BLOCKSZ-1:0]        resp_data_q, resp_data_d;
    logic [NCHAN-1:0]          req_accept_q, req_accept_d;

    logic                      grant_vld;
    logic [CHAN_W-1:0]         grant_idx;

    // First pending channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            int unsigned cand;
            cand = (32'(rr_ptr_q) + i) % NCHAN;
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = CHAN_W'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tag_d        = tag_q;
        beat_d       = beat_q;
        line_d       = line_q;
        rr_ptr_d     = rr_ptr_q;
        resp_data_d  = resp_data_q;
        req_accept_d = '0;

        case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    chan_d  = grant_idx;
                    write_d = req_write[grant_idx];
                    addr_d  = req_addr[grant_idx*WORDSZ +: WORDSZ] & ADDR_MASK;
                    wdata_d = req_wdata[grant_idx*BLOCKSZ +: BLOCKSZ];
                    tag_d   = {req_write[grant_idx], 4'b0001, ID_W'(grant_idx)};
                    beat_d  = '0;
                    req_accept_d[grant_idx] = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (bus_reqack) begin
                    state_d = write_q ? StWdata : StRdata;
                end
            end
            StWdata: begin
                if (bus_reqack) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = StDone;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StRdata: begin
                // Beats carrying another transaction's tag are acked but dropped.
                if (bus_respcyc && (bus_resptag == tag_q)) begin
                    line_d[beat_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
                    if (beat_q == LAST_BEAT) begin
                        beat_d      = '0;
                        resp_data_d = line_d;
                        state_d     = StDone;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StDone: begin
                rr_ptr_d = CHAN_W'((32'(chan_q) + 1) % NCHAN);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        resp_valid  = '0;
        case (state_q)
            StAddr: begin
                bus_reqcyc = 1'b1;
                bus_req    = BUS_DATA_WIDTH'(addr_q);
                bus_reqtag = tag_q;
            end
            StWdata: begin
                bus_reqcyc = 1'b1;
                bus_req    = wdata_q[beat_q*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                bus_reqtag = tag_q;
            end
            StRdata: bus_respack = bus_respcyc;
            StDone:  resp_valid[chan_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            chan_q       <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            tag_q        <= '0;
            beat_q       <= '0;
            line_q       <= '0;
            rr_ptr_q     <= '0;
            resp_data_q  <= '0;
            req_accept_q <= '0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tag_q        <= tag_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_data_q  <= resp_data_d;
            req_accept_q <= req_accept_d;
        end
    end

    assign req_accept = req_accept_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random rounds against a queue-based arbitration/memory model,
// plus directed plan cases and a 4-channel, 256-bit-line instance.
module tb_mem_arbiter;
    localparam int NCH = 2, BLK = 512, BDW = 64, BTW = 13, AW = 64, BEATS = 8;

    typedef struct packed {
        logic [63:0]     addr;
        logic [BTW-1:0]  tag;
        logic            wr;
        logic [BLK-1:0]  wdata;
    } bus_t;
    typedef struct packed {
        logic [7:0]      chan;
        logic            wr;
        logic [BLK-1:0]  data;
    } resp_t;

    logic clk, reset;
    logic [NCH-1:0] req_valid, req_write, req_accept, resp_valid;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*BLK-1:0] req_wdata;
    logic [BLK-1:0] resp_data;
    logic bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [BTW-1:0] bus_reqtag, bus_resptag;
    logic [BDW-1:0] bus_req, bus_resp;

    logic [3:0] req_valid4, req_write4, req_accept4, resp_valid4;
    logic [4*AW-1:0] req_addr4;
    logic [4*256-1:0] req_wdata4;
    logic [255:0] resp_data4;
    logic bus_reqcyc4, bus_reqack4, bus_respcyc4, bus_respack4;
    logic [BTW-1:0] bus_reqtag4, bus_resptag4;
    logic [BDW-1:0] bus_req4, bus_resp4;

    mem_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_accept(req_accept),
        .resp_valid(resp_valid), .resp_data(resp_data), .bus_reqcyc(bus_reqcyc),
        .bus_reqtag(bus_reqtag), .bus_req(bus_req), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resptag(bus_resptag), .bus_resp(bus_resp),
        .bus_respack(bus_respack)
    );

    mem_arbiter #(.NCHAN(4), .BLOCKSZ(256)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid4), .req_write(req_write4),
        .req_addr(req_addr4), .req_wdata(req_wdata4), .req_accept(req_accept4),
        .resp_valid(resp_valid4), .resp_data(resp_data4), .bus_reqcyc(bus_reqcyc4),
        .bus_reqtag(bus_reqtag4), .bus_req(bus_req4), .bus_reqack(bus_reqack4),
        .bus_respcyc(bus_respcyc4), .bus_resptag(bus_resptag4), .bus_resp(bus_resp4),
        .bus_respack(bus_respack4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, acc_cyc = 0, last_lat = 0;
    int n_resp = 0, n_target = 0, rd_beats = 0;
    int model_rr = 0;
    logic [BLK-1:0] model_last = '0;
    int dly_mode = 0, gap_mode = 0, foreign_at = -1;

    bus_t  exp_bus[$];
    resp_t exp_resp[$];
    int    exp_acc[$];

    logic [63:0]    r_addr[NCH];
    logic [BLK-1:0] r_wdata[NCH];
    logic [NCH-1:0] r_wr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Backing-store contents seen by reads: depends only on line address and beat.
    function automatic logic [63:0] mem_beat(input logic [63:0] a, input int b);
        return (a >> 4) + 64'(b);
    endfunction

    function automatic int pick_dly();
        return (dly_mode >= 0) ? dly_mode : int'($urandom_range(0, 2));
    endfunction

    // Reference: pending set swept round-robin; each grant moves the pointer past the winner.
    task automatic issue_round(input logic [NCH-1:0] mask);
        logic [NCH-1:0] pend;
        int k;
        bus_t bx;
        resp_t rx;
        pend = mask;
        while (pend != 0) begin
            k = model_rr;
            while (!pend[k]) k = (k + 1) % NCH;
            pend[k] = 1'b0;
            model_rr = (k + 1) % NCH;
            bx.addr = r_addr[k] & ~64'h3F;
            bx.tag = {r_wr[k], 4'b0001, 8'(k)};
            bx.wr = r_wr[k];
            bx.wdata = r_wdata[k];
            rx.chan = 8'(k);
            rx.wr = r_wr[k];
            if (r_wr[k]) rx.data = model_last;
            else begin
                for (int i = 0; i < BEATS; i++) rx.data[i*BDW +: BDW] = mem_beat(bx.addr, i);
                model_last = rx.data;
            end
            exp_bus.push_back(bx);
            exp_resp.push_back(rx);
            exp_acc.push_back(k);
        end
        for (int c = 0; c < NCH; c++) begin
            req_addr[c*AW +: AW] = r_addr[c];
            req_wdata[c*BLK +: BLK] = r_wdata[c];
        end
        req_write = r_wr;
        req_valid = mask;
        n_target = n_resp + $countones(mask);
    endtask

    task automatic wait_round();
        int c;
        c = 0;
        while (n_resp < n_target && c < 3000) begin
            @(negedge clk);
            req_valid &= ~req_accept;
            c++;
        end
        check("round_done", 512'(n_resp >= n_target), 512'(1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic run_round(input logic [NCH-1:0] mask);
        issue_round(mask);
        wait_round();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (req_accept != 0) begin
                acc_cyc = cyc;
                if (exp_acc.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL accept_unexpected: got %b expected none", req_accept);
                end else begin
                    int k;
                    k = exp_acc.pop_front();
                    check("accept_chan", 512'(req_accept), 512'(1 << k));
                end
            end
            if (resp_valid != 0) begin
                last_lat = cyc - acc_cyc;
                if (exp_resp.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL resp_unexpected: got %b expected none", resp_valid);
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    check("resp_chan", 512'(resp_valid), 512'(1 << e.chan));
                    check("resp_data", resp_data, e.data);
                end
                n_resp++;
            end
        end
    end

    task automatic serve();
        bus_t e;
        logic [BDW-1:0] a0;
        logic [BTW-1:0] t0;
        int d;
        a0 = bus_req;
        t0 = bus_reqtag;
        d = pick_dly();
        repeat (d) begin
            @(posedge clk); #1;
            check("addr_hold", {bus_reqcyc, bus_reqtag, bus_req}, {1'b1, t0, a0});
        end
        if (exp_bus.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL bus_unexpected: got addr %0h tag %0h expected none", bus_req, bus_reqtag);
            bus_reqack = 1'b1; @(posedge clk); #1; bus_reqack = 1'b0;
            return;
        end
        e = exp_bus.pop_front();
        check("bus_addr", bus_req, e.addr);
        check("bus_tag", bus_reqtag, e.tag);
        bus_reqack = 1'b1; @(posedge clk); #1; bus_reqack = 1'b0;
        if (e.wr) begin
            for (int b = 0; b < BEATS; b++) begin
                d = pick_dly();
                repeat (d) begin
                    check("wbeat_hold", {bus_reqcyc, bus_req}, {1'b1, e.wdata[b*BDW +: BDW]});
                    @(posedge clk); #1;
                end
                check("wbeat", {bus_reqcyc, bus_reqtag, bus_req}, {1'b1, e.tag, e.wdata[b*BDW +: BDW]});
                bus_reqack = 1'b1; @(posedge clk); #1; bus_reqack = 1'b0;
            end
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                if (reset) break;
                if (gap_mode < 0 && $urandom_range(0, 3) == 0) begin
                    bus_respcyc = 1'b0; @(posedge clk); #1;
                end
                if (foreign_at == b || (gap_mode < 0 && $urandom_range(0, 7) == 0)) begin
                    bus_respcyc = 1'b1; bus_resptag = 13'h1FFF; bus_resp = {$urandom, $urandom};
                    #1 check("foreign_ack", 512'(bus_respack), 512'(1));
                    @(posedge clk); #1;
                end
                if (reset) break;
                bus_respcyc = 1'b1; bus_resptag = e.tag; bus_resp = mem_beat(e.addr, b);
                #1 check("rbeat_ack", {bus_reqcyc, bus_respack}, 2'b01);
                @(posedge clk);
                rd_beats++;
                #1;
            end
            bus_respcyc = 1'b0;
        end
    endtask

    initial begin : responder
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resptag = '0; bus_resp = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset && bus_reqcyc) serve();
        end
    end

    task automatic run_dut4();
        logic [BTW-1:0] exp_tag[2], cur_tag;
        logic [3:0] exp_oh[2];
        logic [255:0] line4, wline4;
        int nresp, nacc, nb;
        logic in_tx, is_wr;
        exp_tag[0] = {1'b0, 4'b0001, 8'd1};
        exp_tag[1] = {1'b1, 4'b0001, 8'd3};
        exp_oh[0] = 4'b0010;
        exp_oh[1] = 4'b1000;
        for (int i = 0; i < 4; i++) line4[i*BDW +: BDW] = mem_beat(64'h340, i);
        for (int i = 0; i < 8; i++) wline4[i*32 +: 32] = $urandom;
        req_addr4 = '0; req_wdata4 = '0;
        req_addr4[1*AW +: AW] = 64'h35C;
        req_addr4[3*AW +: AW] = 64'h5010;
        req_wdata4[3*256 +: 256] = wline4;
        req_write4 = 4'b1000;
        req_valid4 = 4'b1010;
        nresp = 0; nacc = 0; nb = 0; in_tx = 1'b0; is_wr = 1'b0; cur_tag = '0;
        for (int c = 0; c < 200 && nresp < 2; c++) begin
            @(posedge clk); #1;
            bus_reqack4 = 1'b0; bus_respcyc4 = 1'b0;
            if (req_accept4 != 0) begin
                if (nacc < 2) check("acc4_chan", 512'(req_accept4), 512'(exp_oh[nacc]));
                nacc++;
                req_valid4 &= ~req_accept4;
            end
            if (resp_valid4 != 0) begin
                check("resp4_chan", 512'(resp_valid4), 512'(exp_oh[nresp]));
                check("resp4_data", 512'(resp_data4), 512'(line4));
                nresp++;
                in_tx = 1'b0;
            end else if (bus_reqcyc4) begin
                bus_reqack4 = 1'b1;
                if (!in_tx) begin
                    check("bus4_tag", 512'(bus_reqtag4), 512'(exp_tag[nresp]));
                    check("bus4_addr", bus_req4, (nresp == 0) ? 64'h340 : 64'h5000);
                    cur_tag = bus_reqtag4; is_wr = bus_reqtag4[BTW-1]; in_tx = 1'b1; nb = 0;
                end else begin
                    if (nb < 4) check("wbeat4", bus_req4, wline4[nb*BDW +: BDW]);
                    nb++;
                end
            end else if (in_tx && !is_wr && nb < 4) begin
                bus_respcyc4 = 1'b1; bus_resptag4 = cur_tag; bus_resp4 = mem_beat(64'h340, nb);
                nb++;
            end
        end
        bus_reqack4 = 1'b0; bus_respcyc4 = 1'b0;
        check("dut4_done", 512'(nresp), 512'(2));
    endtask

    initial begin : main
        reset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_valid4 = '0; req_write4 = '0; req_addr4 = '0; req_wdata4 = '0;
        bus_reqack4 = 1'b0; bus_respcyc4 = 1'b0; bus_resptag4 = '0; bus_resp4 = '0;
        for (int c = 0; c < NCH; c++) begin r_addr[c] = '0; r_wdata[c] = '0; end
        r_wr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {req_accept, resp_valid, bus_reqcyc, bus_respack, bus_req, bus_reqtag},
              '0);
        check("rst_resp_data", resp_data, '0);
        @(negedge clk) reset = 1'b0;

        // Both channels pending from reset; slow (2-cycle) acks.
        dly_mode = 2; gap_mode = 0;
        r_addr[0] = 64'h1034; r_wr[0] = 1'b0;
        r_addr[1] = 64'h2000; r_wr[1] = 1'b1;
        for (int b = 0; b < BEATS; b++) r_wdata[1][b*BDW +: BDW] = 64'hA0 + 64'(b);
        run_round(2'b11);
        check("plan_word0", resp_data[63:0], 64'h100);
        check("plan_word7", resp_data[511:448], 64'h107);

        // Pointer has wrapped to 0: ch0 first again.
        dly_mode = -1;
        r_addr[0] = {$urandom, $urandom}; r_addr[1] = {$urandom, $urandom};
        r_wr = 2'b01;
        run_round(2'b11);

        dly_mode = 0;
        r_wr = 2'b00; r_addr[1] = {$urandom, $urandom};
        run_round(2'b10);
        check("read_latency", 512'(last_lat), 512'(BEATS + 1));
        r_wr = 2'b01;
        for (int j = 0; j < 16; j++) r_wdata[0][j*32 +: 32] = $urandom;
        run_round(2'b01);
        check("write_latency", 512'(last_lat), 512'(BEATS + 1));

        foreign_at = 4; r_wr = 2'b00; r_addr[0] = 64'h1034;
        run_round(2'b01);
        foreign_at = -1;

        // Abort a read after beat 4 has been stored.
        r_addr[0] = 64'h3000;
        rd_beats = 0;
        issue_round(2'b01);
        for (int c = 0; c < 200 && rd_beats < 5; c++) begin
            @(negedge clk);
            req_valid &= ~req_accept;
        end
        check("reached_beat4", 512'(rd_beats), 512'(5));
        reset = 1'b1;
        #1;
        check("midrst_outputs", {req_accept, resp_valid, bus_reqcyc, bus_respack, bus_req, bus_reqtag},
              '0);
        check("midrst_resp_data", resp_data, '0);
        exp_resp.delete(); exp_bus.delete(); exp_acc.delete();
        req_valid = '0;
        model_rr = 0; model_last = '0; n_target = n_resp;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        r_addr[1] = 64'h4444;
        run_round(2'b10);

        dly_mode = -1; gap_mode = -1;
        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < NCH; c++) begin
                r_wr[c] = 1'($urandom_range(0, 1));
                r_addr[c] = {$urandom, $urandom};
                for (int j = 0; j < 16; j++) r_wdata[c][j*32 +: 32] = $urandom;
            end
            run_round(NCH'($urandom_range(1, 3)));
        end

        run_dut4();

        check("exp_bus_empty", 512'(exp_bus.size()), '0);
        check("exp_resp_empty", 512'(exp_resp.size()), '0);
        check("exp_acc_empty", 512'(exp_acc.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
